ibex_crypto_ctrl: RTL
=====================

// Module: ibex_crypto_ctrl
// PURPOSE
//   Issue/sequencing controller for the crypto datapath (sha2_unit, aes_unit) in the EX stage.
//   Accepts one crypto op from ID per valid/ready handshake and registers its operands.
//   Drives the unit enables for a programmable number of cycles, then captures the result.
//   Holds the result with a valid flag until ID consumes it. Supports flush on exception/kill.
// PARAMETERS
//   Sha2Latency  1  cycles sha2_en_o is held before the result is captured (legal 1..15)
//   AesLatency   2  cycles aes_en_o is held before the result is captured (legal 1..15)
// PORTS
//   clk_i          in   1   clock
//   rst_ni         in   1   reset: asynchronous assert, active-low
//   req_valid_i    in   1   ID presents a crypto op
//   req_ready_o    out  1   op accepted on a cycle where req_valid_i && req_ready_o
//   req_sel_i      in   1   0 = SHA2 op, 1 = AES op
//   sha2_op_i      in   sha2_op_t  SHA2 sub-op; sampled at accept
//   aes_mix_i      in   1   AES mix-column select; sampled at accept
//   aes_bs_i       in   2   AES byte select; sampled at accept
//   op_a_i/op_b_i  in   32  rs1/rs2 operands; sampled at accept
//   flush_i        in   1   abort the in-flight op
//   ready_id_i     in   1   ID consumes the result
//   sha2_en_o      out  1   SHA2 unit enable
//   sha2_op_o      out  sha2_op_t  SHA2 sub-op to the unit
//   aes_en_o       out  1   AES unit enable
//   aes_mix_o      out  1   AES mix-column select to the unit
//   aes_bs_o       out  2   AES byte select to the unit
//   unit_a_o/unit_b_o  out  32  operands to the units; 0 when no unit is enabled
//   sha2_result_i/aes_result_i  in  32  combinational results from the units
//   result_o       out  32  held result
//   valid_o        out  1   result_o valid
//   busy_o         out  1   state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, all regs 0; every output 0 except req_ready_o=1.
//   States:
//     IDLE: req_ready_o=1. On accept, latch sel/op/mix/bs/operands,
//       set cnt = (sel ? AesLatency : Sha2Latency) - 1, then go to EXEC.
//     EXEC: drive the selected unit enable and operands from the latched regs.
//       If cnt!=0, decrement. If cnt==0, capture the selected unit result into result_o and go to DONE.
//     DONE: valid_o=1, result_o stable. If ready_id_i=1, leave DONE:
//       with req_valid_i also 1, accept the next op the same cycle and go to EXEC;
//       otherwise go to IDLE.
//   req_ready_o = (state==IDLE) || (state==DONE && ready_id_i) && !flush_i.
//   Latency: accept at edge 0 -> EXEC cycles 1..L -> valid_o high from cycle L+1.
//     L = AesLatency or Sha2Latency.
//   Only one enable is high at a time. Enables are low outside EXEC.
//     unit_a_o/unit_b_o are forced to 0 outside EXEC (gating).
//   Flush: flush_i=1 in any state -> IDLE next cycle; valid_o=0, result_o cleared, enables low.
//     Flush has priority over accept and over ready_id_i in the same cycle.
//     No accept occurs in a flush cycle.
//   ready_id_i outside DONE is ignored. req_valid_i while busy (not DONE && ready_id_i) is stalled.
//     ID must hold the request stable.
//   Async reset mid-EXEC: immediate return to reset values; no result is produced.
//   Counter width is 4 bits. Assertions: 1 <= latency params <= 15; never sha2_en_o && aes_en_o.
// TESTING
//   SHA2 sel=0, a=32'h0123_4567, Sha2Latency=1:
//     sha2_en_o high for 1 cycle; valid_o at cycle 2; result_o = sha2_result_i sampled in cycle 1.
//   AES sel=1, bs=2'd3, AesLatency=2:
//     aes_en_o high in cycles 1-2; aes_bs_o=3; valid_o at cycle 3; req_ready_o=0 in cycles 1-2.
//   Hold: ready_id_i=0 for 5 cycles in DONE:
//     valid_o and result_o stay stable; ready_id_i=1 -> IDLE next cycle with valid_o=0.
//   Back-to-back: second req_valid_i with ready_id_i=1 in DONE:
//     accepted the same cycle; EXEC next cycle; no IDLE bubble.
//   Flush in EXEC cycle 1 of AES, with req_valid_i=1:
//     next cycle IDLE, aes_en_o=0, valid_o never rises; no accept in the flush cycle.
//   rst_ni low mid-EXEC: outputs immediately return to reset values; req_ready_o=1 after release.

Source files
------------

// File: rtl/ibex_crypto_ctrl.sv
// Crypto issue controller: accepts one SHA2/AES op, enables the unit, captures and holds its result.
// Latency: accept at edge 0, unit enabled cycles 1..L, valid_o from cycle L+1 (L = per-unit parameter).
// Backpressure: req_ready_o low while an op is executing or a result waits for ready_id_i; flush aborts.
package ibex_crypto_ctrl_pkg;
   typedef logic [2:0] sha2_op_t;
endpackage

module ibex_crypto_ctrl
   import ibex_crypto_ctrl_pkg::*;
#(
   parameter int unsigned Sha2Latency = 1,
   parameter int unsigned AesLatency  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_sel_i,
   input  sha2_op_t    sha2_op_i,
   input  logic        aes_mix_i,
   input  logic [1:0]  aes_bs_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        flush_i,
   input  logic        ready_id_i,
   output logic        sha2_en_o,
   output sha2_op_t    sha2_op_o,
   output logic        aes_en_o,
   output logic        aes_mix_o,
   output logic [1:0]  aes_bs_o,
   output logic [31:0] unit_a_o,
   output logic [31:0] unit_b_o,
   input  logic [31:0] sha2_result_i,
   input  logic [31:0] aes_result_i,
   output logic [31:0] result_o,
   output logic        valid_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter preload: remaining EXEC cycles after the first one.
   localparam logic [3:0] Sha2Cnt = 4'(Sha2Latency - 1);
   localparam logic [3:0] AesCnt  = 4'(AesLatency - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q;
   logic        sel_q;
   sha2_op_t    op_q;
   logic        mix_q;
   logic [1:0]  bs_q;
   logic [31:0] a_q, b_q;
   logic [31:0] result_q;
   logic        accept;
   logic        capture;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand latches, cycle counter and result capture; flush wipes counter and result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         op_q     <= '0;
         mix_q    <= 1'b0;
         bs_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else if (flush_i) begin
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            sel_q <= req_sel_i;
            op_q  <= sha2_op_i;
            mix_q <= aes_mix_i;
            bs_q  <= aes_bs_i;
            a_q   <= op_a_i;
            b_q   <= op_b_i;
            cnt_q <= req_sel_i ? AesCnt : Sha2Cnt;
         end else if (state_q == EXEC && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (capture) begin
            result_q <= sel_q ? aes_result_i : sha2_result_i;
         end
      end
   end

   // Next-state and unit drive; unit-facing outputs are gated to zero outside EXEC.
   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      sha2_en_o   = 1'b0;
      sha2_op_o   = '0;
      aes_en_o    = 1'b0;
      aes_mix_o   = 1'b0;
      aes_bs_o    = '0;
      unit_a_o    = '0;
      unit_b_o    = '0;
      req_ready_o = ((state_q == IDLE) || (state_q == DONE && ready_id_i)) && !flush_i;
      accept      = req_valid_i && req_ready_o;
      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            unit_a_o = a_q;
            unit_b_o = b_q;
            if (sel_q) begin
               aes_en_o  = 1'b1;
               aes_mix_o = mix_q;
               aes_bs_o  = bs_q;
            end else begin
               sha2_en_o = 1'b1;
               sha2_op_o = op_q;
            end
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (ready_id_i) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   assign result_o = result_q;
   assign valid_o  = (state_q == DONE);
   assign busy_o   = (state_q != IDLE);

   // Latency parameters must fit the 4-bit counter and be non-zero; units are mutually exclusive.
   a_lat_range: assert property (@(posedge clk_i)
      (Sha2Latency >= 1) && (Sha2Latency <= 15) && (AesLatency >= 1) && (AesLatency <= 15));
   a_one_hot_en: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(sha2_en_o && aes_en_o));

endmodule
